multiplier_pp_param: RTL

MULTIPLIER_PP_PARAM -- requirements
Module: multiplier_pp_param

---
 rtl/multiplier_pp_pkg.sv | 24 ++
 rtl/pp_delay_line.sv | 48 ++++
 rtl/multiplier_pp_param.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/multiplier_pp_pkg.sv
// ---------------------------------------------------------------------------
// multiplier_pp_pkg
// Shared constants and sizing helpers for the partial-product multiplier.
// No ports. Packages cannot be parameterised, so the per-instance sizes
// (chunk count, output width) are constant functions of the instance
// parameters rather than fixed localparams.
// ---------------------------------------------------------------------------
package multiplier_pp_pkg;

    // Value of iSigned selecting each operand interpretation
    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // NCHUNK: number of CWIDTH-bit chunks per operand
    function automatic int nchunk(input int iwidth, input int cwidth);
        return iwidth / cwidth;
    endfunction

    // OWIDTH: full product width
    function automatic int owidth(input int iwidth);
        return 2 * iwidth;
    endfunction

endpackage

// File: rtl/pp_delay_line.sv
// ---------------------------------------------------------------------------
// pp_delay_line
// Enable/clear shift register carrying a data word plus its valid bit.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   en_i           advance; when low every stage holds
//   clr_i          synchronous flush (overrides en_i)
//   d_i, v_i       data/valid entering stage 0
//   d_o, v_o       data/valid leaving the last stage
//   busy_o         OR of all stage valid bits
// ---------------------------------------------------------------------------
module pp_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    input  logic         v_i,
    output logic [W-1:0] d_o,
    output logic         v_o,
    output logic         busy_o
);

    logic [DEPTH-1:0][W-1:0] data_q;
    logic [DEPTH-1:0]        vld_pipe_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            data_q     <= '0;
            vld_pipe_q <= '0;
        end else if (en_i) begin
            data_q[0]     <= d_i;
            vld_pipe_q[0] <= v_i;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k]     <= data_q[k-1];
                vld_pipe_q[k] <= vld_pipe_q[k-1];
            end
        end
    end

    assign d_o    = data_q[DEPTH-1];
    assign v_o    = vld_pipe_q[DEPTH-1];
    assign busy_o = |vld_pipe_q;

endmodule

// File: rtl/multiplier_pp_param.sv
// ---------------------------------------------------------------------------
// multiplier_pp_param
// Pipelined IWIDTH x IWIDTH multiplier, signed or unsigned per transaction,
// built from CWIDTH x CWIDTH chunk partial products. Throughput 1,
// latency PPCYCLE enabled edges (sampling edge counts as the first).
// Ports:
//   iClk, iRst            clock, synchronous active-high reset
//   iEn                   pipeline advance enable (low = hold everything)
//   iClr                  synchronous flush, overrides iEn
//   iValid, iSigned       transaction strobe and its operand mode
//   iData0, iData1        multiplicand, multiplier
//   oData, oValid         registered 2*IWIDTH product and its valid
//   oBusy                 any valid transaction in any stage
// Legal parameters: IWIDTH 8..128 and a multiple of CWIDTH, PPCYCLE >= 2.
// ---------------------------------------------------------------------------
module multiplier_pp_param
    import multiplier_pp_pkg::*;
#(
    parameter int IWIDTH  = 64,
    parameter int CWIDTH  = 16,
    parameter int PPCYCLE = 3
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iValid,
    input  logic                iSigned,
    input  logic [IWIDTH-1:0]   iData0,
    input  logic [IWIDTH-1:0]   iData1,
    output logic [2*IWIDTH-1:0] oData,
    output logic                oValid,
    output logic                oBusy
);

    localparam int NCH = nchunk(IWIDTH, CWIDTH);
    localparam int OW  = owidth(IWIDTH);
    // (C+1)-bit signed x (C+1)-bit signed always fits in 2C+2 bits
    localparam int PPW = 2 * CWIDTH + 2;
    // Edges left after the partial-product register; at PPCYCLE=2 the
    // partial products are formed straight from the ports, so the input
    // register is dropped and the sum goes directly into the output stage.
    localparam int DLD = (PPCYCLE >= 3) ? PPCYCLE - 2 : 1;

    logic [IWIDTH-1:0] a_s, b_s;
    logic              sgn_s, vld_s, ibusy;

    // ---------------- stage 1: operand register ----------------
    generate
        if (PPCYCLE >= 3) begin : g_ireg
            logic [IWIDTH-1:0] a_q, b_q;
            logic              sgn_q, vld_q;

            always_ff @(posedge iClk) begin
                if (iRst || iClr) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sgn_q <= 1'b0;
                    vld_q <= 1'b0;
                end else if (iEn) begin
                    a_q   <= iData0;
                    b_q   <= iData1;
                    sgn_q <= iSigned;
                    vld_q <= iValid;
                end
            end

            assign a_s   = a_q;
            assign b_s   = b_q;
            assign sgn_s = sgn_q;
            assign vld_s = vld_q;
            assign ibusy = vld_q;
        end else begin : g_noireg
            assign a_s   = iData0;
            assign b_s   = iData1;
            assign sgn_s = iSigned;
            assign vld_s = iValid;
            assign ibusy = 1'b0;
        end
    endgenerate

    // ---------------- stage 2: chunk partial products ----------------
    // Each chunk is widened by one bit: zero for unsigned operands and for
    // all lower chunks, the operand sign for the top chunk in signed mode.
    // The chunk sum then equals the true product modulo 2^OW in both modes.
    logic signed [CWIDTH:0]  ea [NCH];
    logic signed [CWIDTH:0]  eb [NCH];
    logic signed [PPW-1:0]   pp_d [NCH][NCH];
    logic signed [PPW-1:0]   pp_q [NCH][NCH];
    logic                    vpp_q;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ea[i] = {(sgn_s == MODE_SIGNED) && (i == NCH - 1) && a_s[i*CWIDTH+CWIDTH-1],
                     a_s[i*CWIDTH +: CWIDTH]};
            eb[i] = {(sgn_s == MODE_SIGNED) && (i == NCH - 1) && b_s[i*CWIDTH+CWIDTH-1],
                     b_s[i*CWIDTH +: CWIDTH]};
        end
        for (int i = 0; i < NCH; i++)
            for (int j = 0; j < NCH; j++)
                pp_d[i][j] = PPW'(ea[i]) * PPW'(eb[j]);
    end

    always_ff @(posedge iClk) begin
        if (iRst || iClr) begin
            for (int i = 0; i < NCH; i++)
                for (int j = 0; j < NCH; j++)
                    pp_q[i][j] <= '0;
            vpp_q <= 1'b0;
        end else if (iEn) begin
            pp_q  <= pp_d;
            vpp_q <= vld_s;
        end
    end

    // ---------------- sum of shifted partial products ----------------
    // Bubbles are forced to zero here so an invalid output slot reads 0.
    logic [OW-1:0] sum_d;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NCH; i++)
            for (int j = 0; j < NCH; j++)
                sum_d = sum_d + (OW'(pp_q[i][j]) << ((i + j) * CWIDTH));
        if (!vpp_q)
            sum_d = '0;
    end

    // ---------------- remaining stages, last one is oData ----------------
    logic dl_busy;

    pp_delay_line #(
        .W     (OW),
        .DEPTH (DLD)
    ) u_dly (
        .clk_i  (iClk),
        .rst_i  (iRst),
        .en_i   (iEn),
        .clr_i  (iClr),
        .d_i    (sum_d),
        .v_i    (vpp_q),
        .d_o    (oData),
        .v_o    (oValid),
        .busy_o (dl_busy)
    );

    assign oBusy = ibusy | vpp_q | dl_busy;

endmodule
